// File: rtl/shift_reg_pkg.sv
// Package: shift_reg_pkg
// Purpose: Shared word width and word type for the parallel-load shift
//          register, its bus interface and any block that drives or
//          observes it.
// Contents:
//   SR_WIDTH  - default register width in bits
//   sr_word_t - one register-wide word
package shift_reg_pkg;

  localparam int SR_WIDTH = 4;

  typedef logic [SR_WIDTH-1:0] sr_word_t;

endpackage : shift_reg_pkg

// File: rtl/intf.sv
// Interface: intf
// Purpose: Bundles the shift register's control, load data and output word
//          so that a driver and a passive monitor can share one connection.
// Ports:
//   clk - shared clock, passed through to both modports
// Modports:
//   DRIVER  - drives reset/load/parallel_data_in, observes serial_data_out
//   MONITOR - observes every signal, drives nothing
interface intf
  import shift_reg_pkg::*;
(
  input logic clk
);

  logic     reset;
  logic     load;
  sr_word_t parallel_data_in;
  sr_word_t serial_data_out;

  modport DRIVER (
    input  clk,
    output reset,
    output load,
    output parallel_data_in,
    input  serial_data_out
  );

  modport MONITOR (
    input clk,
    input reset,
    input load,
    input parallel_data_in,
    input serial_data_out
  );

endinterface : intf

// File: rtl/modport_shift_reg.sv
// Module: modport_shift_reg
// Purpose: WIDTH-bit parallel-load shift register. On each rising clock edge
//          it clears (reset), loads a parallel word (load) or shifts one
//          position, filling the vacated end with FILL_BIT. The register is
//          driven straight out; with a right shift bit 0 is the serial bit.
// Parameters:
//   WIDTH      - register width in bits (>= 2)
//   SHIFT_LEFT - 0: shift toward bit 0, 1: shift toward the MSB
//   FILL_BIT   - value shifted into the vacated end
// Ports:
//   clk              - clock, all state changes on posedge
//   reset            - synchronous active-high clear, beats load
//   load             - 1: capture parallel_data_in, 0: shift
//   parallel_data_in - parallel load word
//   serial_data_out  - current register contents (registered output)
module modport_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int   WIDTH      = SR_WIDTH,
  parameter int   SHIFT_LEFT = 0,
  parameter logic FILL_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_data_in,
  output logic [WIDTH-1:0] serial_data_out
);

  logic [WIDTH-1:0] sr_reg;
  logic [WIDTH-1:0] shift_next;

  // Direction is fixed at elaboration, so only one shifter is built.
  // There is no rotate: once WIDTH shifts have happened the register is
  // all FILL_BIT and stays there until the next load.
  generate
    if (SHIFT_LEFT != 0) begin : g_shift_left
      assign shift_next = {sr_reg[WIDTH-2:0], FILL_BIT};
    end else begin : g_shift_right
      assign shift_next = {FILL_BIT, sr_reg[WIDTH-1:1]};
    end
  endgenerate

  // Priority reset > load > shift. There is no hold state: with load low the
  // register moves every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_reg <= '0;
    end else if (load) begin
      sr_reg <= parallel_data_in;
    end else begin
      sr_reg <= shift_next;
    end
  end

  // Output comes straight from the flops, so there is no input-to-output
  // combinational path.
  assign serial_data_out = sr_reg;

endmodule : modport_shift_reg

// File: tb/tb_modport_shift_reg.sv
// Testbench: tb_modport_shift_reg
// Purpose: Self-checking bench for modport_shift_reg (default 4-bit, right
//          shift, fill 0). Directed vectors are listed in a table; the
//          reset-during-shift case is written by hand; then 200 random
//          cycles are compared against an arithmetic reference model.
// Ports: none (top-level bench).
module tb_modport_shift_reg;
  import shift_reg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  intf bus (.clk(clk));

  modport_shift_reg dut (
    .clk              (clk),
    .reset            (bus.reset),
    .load             (bus.load),
    .parallel_data_in (bus.parallel_data_in),
    .serial_data_out  (bus.serial_data_out)
  );

  typedef struct {
    logic     rst;
    logic     ld;
    sr_word_t din;
    sr_word_t expect_out;
  } vec_t;

  int tests_run = 0;
  int tests_failed = 0;
  int txn = 0;

  // Reference model: the register value held as an integer. A right shift
  // with fill 0 is plain integer division by two.
  int model_val = 0;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change #1 after a rising edge; the result of the next edge is
  // sampled #1 after that edge.
  task automatic apply(input logic rst, input logic ld, input sr_word_t din);
    bus.reset            = rst;
    bus.load             = ld;
    bus.parallel_data_in = din;
    @(posedge clk);
    #1;
    txn++;
  endtask

  function automatic int model_step(input int cur, input logic rst,
                                    input logic ld, input int din);
    if (rst)     return 0;
    else if (ld) return din;
    else         return cur / 2;
  endfunction

  vec_t vecs[$];

  initial begin
    bus.reset            = 1'b1;
    bus.load             = 1'b1;
    bus.parallel_data_in = 4'hF;

    // Reset with load high, load of a word, shift-out, reload mid-shift,
    // and back-to-back loads.
    vecs = '{
      '{1'b1, 1'b1, 4'hF, 4'h0},
      '{1'b1, 1'b1, 4'hF, 4'h0},
      '{1'b0, 1'b1, 4'b1011, 4'b1011},
      '{1'b0, 1'b0, 4'h0, 4'b0101},
      '{1'b0, 1'b0, 4'h0, 4'b0010},
      '{1'b0, 1'b0, 4'h0, 4'b0001},
      '{1'b0, 1'b0, 4'h0, 4'b0000},
      '{1'b0, 1'b0, 4'h0, 4'b0000},
      '{1'b0, 1'b1, 4'b1000, 4'b1000},
      '{1'b0, 1'b0, 4'hF, 4'b0100},
      '{1'b0, 1'b0, 4'hF, 4'b0010},
      '{1'b0, 1'b1, 4'b0110, 4'b0110},
      '{1'b0, 1'b1, 4'h3, 4'h3},
      '{1'b0, 1'b1, 4'hC, 4'hC},
      '{1'b0, 1'b1, 4'h9, 4'h9}
    };

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].ld, vecs[i].din);
      $display("[TB] txn %0d vec %0d rst=%b ld=%b din=%h out=%h exp=%h", txn, i,
               vecs[i].rst, vecs[i].ld, vecs[i].din, bus.serial_data_out,
               vecs[i].expect_out);
      check($sformatf("vec%0d", i), int'(bus.serial_data_out),
            int'(vecs[i].expect_out));
    end

    // Reset in the middle of a shift, with a load on the same edge.
    apply(1'b0, 1'b1, 4'hF);
    $display("[TB] txn %0d load F out=%h", txn, bus.serial_data_out);
    check("rst_mid_load", int'(bus.serial_data_out), 'hF);
    apply(1'b0, 1'b0, 4'h0);
    $display("[TB] txn %0d shift out=%h", txn, bus.serial_data_out);
    check("rst_mid_shift", int'(bus.serial_data_out), 'h7);
    apply(1'b1, 1'b1, 4'hA);
    $display("[TB] txn %0d reset+load A out=%h", txn, bus.serial_data_out);
    check("rst_beats_load", int'(bus.serial_data_out), 'h0);
    apply(1'b0, 1'b0, 4'h0);
    $display("[TB] txn %0d shift after reset out=%h", txn, bus.serial_data_out);
    check("rst_then_shift", int'(bus.serial_data_out), 'h0);
    model_val = 0;

    // Random traffic against the model; bit 0 is the serial stream.
    for (int n = 0; n < 200; n++) begin
      logic     r;
      logic     l;
      sr_word_t d;
      r = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 2) == 0);
      d = sr_word_t'($urandom_range(0, 15));
      apply(r, l, d);
      model_val = model_step(model_val, r, l, int'(d));
      $display("[TB] txn %0d rnd rst=%b ld=%b din=%h out=%h exp=%h", txn,
               r, l, d, bus.serial_data_out, model_val);
      check($sformatf("rnd%0d_word", n), int'(bus.serial_data_out), model_val);
      check($sformatf("rnd%0d_serial", n), int'(bus.serial_data_out[0]),
            model_val % 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_modport_shift_reg
